// File: rtl/modify_uart_pkg.sv
// Shared UART definitions: FSM state encoding and bit-timing constants.
// Used by both the receiver and the transmitter.
package modify_uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_REC_BYTE = 3'd2,
        S_PARITY   = 3'd3,
        S_STOP     = 3'd4
    } uart_state_t;

    localparam int FREQ_MHZ_DEF = 50;
    localparam int BAUD_DEF     = 115200;
    localparam int DATA_W_DEF   = 8;

    function automatic int calc_cycle(input int mhz, input int baud);
        return (mhz * 1000000) / baud;
    endfunction

    function automatic int calc_half(input int mhz, input int baud);
        return calc_cycle(mhz, baud) / 2;
    endfunction

    localparam int CYCLE_DEF = calc_cycle(FREQ_MHZ_DEF, BAUD_DEF);
    localparam int HALF_DEF  = calc_half(FREQ_MHZ_DEF, BAUD_DEF);

endpackage

// File: rtl/modify_uart_rx_if.sv
// Receiver output bundle: word/valid/ready handshake plus error pulses.
// Optional parity error pulse exists only with MODIFY_UART_RX_PARITY_EN.
interface modify_uart_rx_if #(
    parameter int W = 8
);
    logic [W-1:0] rx_data;
    logic         rx_data_valid;
    logic         rx_data_ready;
    logic         rx_frame_err;
    logic         rx_overrun;
`ifdef MODIFY_UART_RX_PARITY_EN
    logic         rx_parity_err;

    modport master (
        output rx_data, rx_data_valid, rx_frame_err,
        output rx_overrun, rx_parity_err,
        input  rx_data_ready
    );
    modport slave (
        input  rx_data, rx_data_valid, rx_frame_err,
        input  rx_overrun, rx_parity_err,
        output rx_data_ready
    );
`else
    modport master (
        output rx_data, rx_data_valid, rx_frame_err,
        output rx_overrun,
        input  rx_data_ready
    );
    modport slave (
        input  rx_data, rx_data_valid, rx_frame_err,
        input  rx_overrun,
        output rx_data_ready
    );
`endif
endinterface

// File: rtl/modify_uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus a falling-edge detect
// taken from the synchronized signal and one extra history flop.
module uart_rx_sync (
    input  logic clk,
    input  logic n_reset,
    input  logic rx_pin,
    output logic rx_s,
    output logic rx_fall
);

    logic [2:0] sh;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) sh <= 3'b111;
        else          sh <= {sh[1:0], rx_pin};
    end

    assign rx_s    = sh[1];
    assign rx_fall = sh[2] & ~sh[1];

endmodule

// File: rtl/modify_uart_rx.sv
// UART receiver: start/data/stop framing, valid/ready output word.
// Define MODIFY_UART_RX_PARITY_EN to add an even-parity bit after data.
module modify_uart_rx
    import modify_uart_pkg::*;
#(
    parameter int Challenge_Bit     = 8,
    parameter int frequency_clk_ref = 50,
    parameter int BAUD_RATE         = 115200
) (
    input  logic clk,
    input  logic n_reset,
    input  logic rx_pin,
    modify_uart_rx_if.master rx_if
);

    localparam int CYCLE = calc_cycle(frequency_clk_ref, BAUD_RATE);
    localparam int HALF  = calc_half(frequency_clk_ref, BAUD_RATE);
    localparam logic [15:0] CYC_END  = 16'(CYCLE - 1);
    localparam logic [15:0] HALF_END = 16'(HALF - 1);
    localparam logic [4:0]  BIT_END  = 5'(Challenge_Bit - 1);

    uart_state_t state, state_d;
    logic [15:0] cycle_cnt, cycle_cnt_d;
    logic [4:0]  bit_cnt, bit_cnt_d;
    logic [Challenge_Bit-1:0] shift, shift_d;
    logic [Challenge_Bit-1:0] data_q, data_d;
    logic [Challenge_Bit:0]   shifted;
    logic valid_q, valid_d;
    logic ferr_q, ferr_d;
    logic ovr_q, ovr_d;
    logic par_bad;
    logic mid_bit;
    logic rx_s, rx_fall;

    uart_rx_sync u_sync (
        .clk     (clk),
        .n_reset (n_reset),
        .rx_pin  (rx_pin),
        .rx_s    (rx_s),
        .rx_fall (rx_fall)
    );

`ifdef MODIFY_UART_RX_PARITY_EN
    logic perr_q, perr_d;
    logic par_bad_d;
    assign rx_if.rx_parity_err = perr_q;
`else
    assign par_bad = 1'b0;
`endif

    assign shifted = {rx_s, shift};
    assign mid_bit = (cycle_cnt == CYC_END);

    always_comb begin
        state_d     = state;
        cycle_cnt_d = cycle_cnt + 16'd1;
        bit_cnt_d   = bit_cnt;
        shift_d     = shift;
        data_d      = data_q;
        valid_d     = valid_q & ~rx_if.rx_data_ready;
        ferr_d      = 1'b0;
        ovr_d       = 1'b0;
`ifdef MODIFY_UART_RX_PARITY_EN
        perr_d      = 1'b0;
        par_bad_d   = par_bad;
`endif
        unique case (state)
            S_IDLE: begin
                cycle_cnt_d = 16'd0;
                bit_cnt_d   = 5'd0;
`ifdef MODIFY_UART_RX_PARITY_EN
                par_bad_d   = 1'b0;
`endif
                if (rx_fall) state_d = S_START;
            end
            S_START: begin
                if (cycle_cnt == HALF_END) begin
                    cycle_cnt_d = 16'd0;
                    state_d     = rx_s ? S_IDLE : S_REC_BYTE;
                end
            end
            S_REC_BYTE: begin
                if (mid_bit) begin
                    cycle_cnt_d = 16'd0;
                    shift_d     = shifted[Challenge_Bit:1];
                    if (bit_cnt == BIT_END) begin
                        bit_cnt_d = 5'd0;
`ifdef MODIFY_UART_RX_PARITY_EN
                        state_d   = S_PARITY;
`else
                        state_d   = S_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt + 5'd1;
                    end
                end
            end
            S_PARITY: begin
`ifdef MODIFY_UART_RX_PARITY_EN
                if (mid_bit) begin
                    cycle_cnt_d = 16'd0;
                    state_d     = S_STOP;
                    if ((^shift) ^ rx_s) begin
                        perr_d    = 1'b1;
                        par_bad_d = 1'b1;
                    end
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_STOP: begin
                if (mid_bit) begin
                    // leave half a bit early so a back-to-back start is seen
                    cycle_cnt_d = 16'd0;
                    state_d     = S_IDLE;
                    if (!rx_s) begin
                        ferr_d = 1'b1;
                    end else if (!par_bad) begin
                        if (valid_q && !rx_if.rx_data_ready) begin
                            ovr_d = 1'b1;
                        end else begin
                            data_d  = shift;
                            valid_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state     <= S_IDLE;
            cycle_cnt <= 16'd0;
            bit_cnt   <= 5'd0;
            shift     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state     <= state_d;
            cycle_cnt <= cycle_cnt_d;
            bit_cnt   <= bit_cnt_d;
            shift     <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

`ifdef MODIFY_UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            perr_q  <= 1'b0;
            par_bad <= 1'b0;
        end else begin
            perr_q  <= perr_d;
            par_bad <= par_bad_d;
        end
    end
`endif

    assign rx_if.rx_data       = data_q;
    assign rx_if.rx_data_valid = valid_q;
    assign rx_if.rx_frame_err  = ferr_q;
    assign rx_if.rx_overrun    = ovr_q;

endmodule
